// File: rtl/lif_array.sv
// Bank of leaky integrate-and-fire neurons with a shared runtime threshold and a saturating spike
// counter. Define LIF_REFRACTORY_EN to build per-channel refractory counters.
module lif_array #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned IN_W         = 4,
  parameter int unsigned STATE_W      = 8,
  parameter int unsigned LEAK_SHIFT   = 1,
  parameter int unsigned THR_RST      = 127,
  parameter int unsigned REFRAC_STEPS = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step,
  input  logic [N_CH*IN_W-1:0]    current,
  input  logic                    thr_wr,
  input  logic [STATE_W-1:0]      thr_data,
  input  logic                    cnt_clr,
  output logic [N_CH-1:0]         spike,
  output logic [N_CH*STATE_W-1:0] state,
  output logic [STATE_W-1:0]      threshold,
  output logic [CNT_W-1:0]        spike_total
);

  localparam int unsigned PopW = $clog2(N_CH + 1);

  logic [N_CH-1:0][STATE_W-1:0] state_q, state_d;
  logic [N_CH-1:0]              spike_q, spike_d;
  logic [STATE_W-1:0]           thr_q, thr_d;
  logic [CNT_W-1:0]             total_q, total_d;
  logic [STATE_W:0]             sum [N_CH];
  logic [STATE_W-1:0]           sat [N_CH];
  logic [PopW-1:0]              pop;
  logic [CNT_W:0]               total_sum;

`ifdef LIF_REFRACTORY_EN
  localparam logic [3:0] RefracInit = 4'(REFRAC_STEPS);
  logic [N_CH-1:0][3:0] refr_q, refr_d;
`endif

  always_comb begin
    state_d = state_q;
    spike_d = '0;
`ifdef LIF_REFRACTORY_EN
    refr_d  = refr_q;
`endif
    for (int i = 0; i < N_CH; i++) begin
      // One extra bit so the add can be clamped instead of wrapping.
      sum[i] = {1'b0, state_q[i] >> LEAK_SHIFT} + (STATE_W + 1)'(current[i*IN_W +: IN_W]);
      sat[i] = sum[i][STATE_W] ? '1 : sum[i][STATE_W-1:0];
      if (step) begin
`ifdef LIF_REFRACTORY_EN
        if (refr_q[i] != 4'd0) begin
          state_d[i] = '0;
          refr_d[i]  = refr_q[i] - 4'd1;
        end else begin
`else
        begin
`endif
          if (sat[i] >= thr_q) begin
            spike_d[i] = 1'b1;
            state_d[i] = '0;
`ifdef LIF_REFRACTORY_EN
            refr_d[i]  = RefracInit;
`endif
          end else begin
            state_d[i] = sat[i];
          end
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop = pop + PopW'(spike_d[i]);
    end
    total_sum = {1'b0, total_q} + (CNT_W + 1)'(pop);
    // Clear wins over spikes landing in the same cycle.
    if (cnt_clr) begin
      total_d = '0;
    end else if (total_sum[CNT_W]) begin
      total_d = '1;
    end else begin
      total_d = total_sum[CNT_W-1:0];
    end
    thr_d = thr_wr ? thr_data : thr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      spike_q <= '0;
      thr_q   <= STATE_W'(THR_RST);
      total_q <= '0;
`ifdef LIF_REFRACTORY_EN
      refr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      spike_q <= spike_d;
      thr_q   <= thr_d;
      total_q <= total_d;
`ifdef LIF_REFRACTORY_EN
      refr_q  <= refr_d;
`endif
    end
  end

  assign spike       = spike_q;
  assign state       = state_q;
  assign threshold   = thr_q;
  assign spike_total = total_q;

endmodule

// File: tb/tb_lif_array.sv
// Scoreboard bench for lif_array: the driver queues expected outputs per cycle, a negedge monitor
// pops and compares. A second instance with LEAK_SHIFT=0 covers potential saturation.
module tb_lif_array;

  localparam logic [3:0] MSt  = 4'b0001;
  localparam logic [3:0] MSp  = 4'b0010;
  localparam logic [3:0] MTot = 4'b0100;
  localparam logic [3:0] MThr = 4'b1000;

`ifdef LIF_REFRACTORY_EN
  localparam int RefPer = 3;
  logic [7:0]  rf_st  [6] = '{8'd15, 8'd0, 8'd0, 8'd0, 8'd15, 8'd0};
  logic        rf_sp  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] rf_tot [6] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
`else
  localparam int RefPer = 1;
  logic [7:0]  rf_st  [6] = '{8'd15, 8'd0, 8'd15, 8'd0, 8'd15, 8'd0};
  logic        rf_sp  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] rf_tot [6] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3};
`endif

  typedef struct {
    string       name;
    int          cyc;
    int          which;
    logic [3:0]  mask;
    logic [31:0] st;
    logic [3:0]  sp;
    logic [15:0] tot;
    logic [7:0]  thr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step;
  logic [15:0] current;
  logic        thr_wr;
  logic [7:0]  thr_data;
  logic        cnt_clr;
  logic [3:0]  spike, s_spike;
  logic [31:0] state, s_state;
  logic [7:0]  threshold, s_threshold;
  logic [15:0] spike_total, s_spike_total;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total_n = 0;
  int   bad_n = 0;

  lif_array u_dut (
    .clk(clk), .rst_n(rst_n), .step(step), .current(current), .thr_wr(thr_wr),
    .thr_data(thr_data), .cnt_clr(cnt_clr), .spike(spike), .state(state),
    .threshold(threshold), .spike_total(spike_total)
  );

  lif_array #(.LEAK_SHIFT(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .step(step), .current(current), .thr_wr(thr_wr),
    .thr_data(thr_data), .cnt_clr(cnt_clr), .spike(s_spike), .state(s_state),
    .threshold(s_threshold), .spike_total(s_spike_total)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string n, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s.%s act=%0h exp=%0h", n, f, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        cmp(mon_e.name, "missed", 32'(cyc), 32'(mon_e.cyc));
      end else begin
        if (mon_e.mask[0])
          cmp(mon_e.name, "state", (mon_e.which == 0) ? state : s_state, mon_e.st);
        if (mon_e.mask[1])
          cmp(mon_e.name, "spike", 32'((mon_e.which == 0) ? spike : s_spike), 32'(mon_e.sp));
        if (mon_e.mask[2])
          cmp(mon_e.name, "total", 32'((mon_e.which == 0) ? spike_total : s_spike_total),
              32'(mon_e.tot));
        if (mon_e.mask[3])
          cmp(mon_e.name, "thr", 32'((mon_e.which == 0) ? threshold : s_threshold),
              32'(mon_e.thr));
      end
    end
  end

  task automatic cycle(input logic rn, input logic stp, input logic [15:0] cur,
                       input logic tw, input logic [7:0] td, input logic cc);
    rst_n = rn; step = stp; current = cur; thr_wr = tw; thr_data = td; cnt_clr = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string n, input int w, input logic [3:0] m, input logic [31:0] st,
                         input logic [3:0] sp, input logic [15:0] tot, input logic [7:0] th);
    exp_t e;
    e.name = n; e.cyc = cyc; e.which = w; e.mask = m;
    e.st = st; e.sp = sp; e.tot = tot; e.thr = th;
    sb.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; step = 1'b0; current = '0; thr_wr = 1'b0; thr_data = '0; cnt_clr = 1'b0;

    // Reset overrides step, thr_wr and large currents.
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b1, 8'd5, 1'b0);
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b1, 8'd5, 1'b0);
    sb_push("rst", 0, MSt | MSp | MTot | MThr, 32'd0, 4'd0, 16'd0, 8'd127);
    sb_push("rst_sat", 1, MSt | MSp, 32'd0, 4'd0, 16'd0, 8'd0);

    // Firing pattern with threshold 20 and current 15 on channel 0.
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 8'd20, 1'b0);
    sb_push("thr_wr", 0, MSt | MThr, 32'd0, 4'd0, 16'd0, 8'd20);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 16'h000F, 1'b0, 8'd0, 1'b0);
      sb_push("refrac", 0, MSt | MSp | MTot, 32'(rf_st[i]), 4'(rf_sp[i]), rf_tot[i], 8'd0);
    end

    // Reset mid-refractory: channel integrates on the first step after reset.
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0);
    cycle(1'b1, 1'b1, 16'h000F, 1'b0, 8'd0, 1'b0);
    sb_push("post_rst", 0, MSt | MSp | MThr, 32'd15, 4'd0, 16'd0, 8'd127);

    // Gating, then a threshold write racing a step.
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 16'hFFFF, 1'b0, 8'd0, 1'b0);
      sb_push("gate", 0, MSt | MSp, 32'd0, 4'd0, 16'd0, 8'd0);
    end
    cycle(1'b1, 1'b1, 16'h000C, 1'b1, 8'd10, 1'b0);
    sb_push("thr_race", 0, MSt | MSp | MThr, 32'd12, 4'd0, 16'd0, 8'd10);
    cycle(1'b1, 1'b1, 16'h000C, 1'b0, 8'd0, 1'b0);
    sb_push("thr_new", 0, MSt | MSp | MTot, 32'd0, 4'b0001, 16'd1, 8'd0);
    cycle(1'b1, 1'b0, 16'h000C, 1'b0, 8'd0, 1'b0);
    sb_push("one_shot", 0, MSt | MSp, 32'd0, 4'd0, 16'd0, 8'd0);

    // Counter: simultaneous spikes, clear-vs-spike race.
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 8'd10, 1'b0);
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b0, 8'd0, 1'b0);
    sb_push("all4", 0, MSp | MTot, 32'd0, 4'hF, 16'd4, 8'd0);
    for (int i = 0; i < RefPer - 1; i++) cycle(1'b1, 1'b1, 16'hFFFF, 1'b0, 8'd0, 1'b0);
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b0, 8'd0, 1'b1);
    sb_push("clr_win", 0, MSp | MTot, 32'd0, 4'hF, 16'd0, 8'd0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0);
    sb_push("clr_drop", 0, MSp | MTot, 32'd0, 4'd0, 16'd0, 8'd0);

    // Drive the counter to 0xFFFE with threshold 0, then one more 4-spike cycle.
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 8'd0, 1'b0);
    for (int i = 0; i < RefPer - 1; i++) cycle(1'b1, 1'b1, 16'h0000, 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 16383; i++) begin
      for (int j = 0; j < RefPer; j++) cycle(1'b1, 1'b1, 16'h0000, 1'b0, 8'd0, 1'b0);
    end
    sb_push("cnt_pre", 0, MTot, 32'd0, 4'd0, 16'd65532, 8'd0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 8'd10, 1'b0);
    cycle(1'b1, 1'b1, 16'h00FF, 1'b0, 8'd0, 1'b0);
    sb_push("cnt_fffe", 0, MSp | MTot, 32'd0, 4'b0011, 16'hFFFE, 8'd0);
    for (int i = 0; i < RefPer - 1; i++) cycle(1'b1, 1'b1, 16'h0000, 1'b0, 8'd0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 8'd0, 1'b0);
    cycle(1'b1, 1'b1, 16'h0000, 1'b0, 8'd0, 1'b0);
    sb_push("cnt_sat", 0, MSp | MTot, 32'd0, 4'hF, 16'hFFFF, 8'd0);

    // Potential saturation on the no-leak instance: 19*13=247, then 260 clamps to 255.
    cycle(1'b0, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 1'b1, 8'd255, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 16'h000D, 1'b0, 8'd0, 1'b0);
      if (i == 0)  sb_push("sat_first", 1, MSt | MSp, 32'd13, 4'd0, 16'd0, 8'd0);
      if (i == 18) sb_push("sat_19", 1, MSt | MSp, 32'd247, 4'd0, 16'd0, 8'd0);
      if (i == 19) sb_push("sat_clamp", 1, MSt | MSp | MTot, 32'd0, 4'b0001, 16'd1, 8'd0);
    end

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0000, 1'b0, 8'd0, 1'b0);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      cmp(mon_e.name, "unchecked", 32'(cyc), 32'(mon_e.cyc));
    end
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
